// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int BURST_MAX_DEF = 4;

  // Returns {found, index}: first set bit of elig searching upward from last+1, modulo n (n <= 16).
  function automatic logic [4:0] rr_first(input logic [15:0] elig, input logic [3:0] last,
                                          input int unsigned n);
    logic        found;
    logic [3:0]  idx;
    int unsigned cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 16; k++) begin
      if (k <= n && !found) begin
        cand = (32'(last) + k) % n;
        if (elig[cand[3:0]]) begin
          found = 1'b1;
          idx   = cand[3:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: picks the first eligible index after last_winner.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int num_req  = NUM_REQ_DEF,
  parameter int id_width = $clog2(num_req)
) (
  input  logic [num_req-1:0]  eligible,
  input  logic [id_width-1:0] last_winner,
  output logic [id_width-1:0] winner,
  output logic                any_eligible
);

  logic [4:0] w_pick;

  assign w_pick       = rr_first(16'(eligible), 4'(last_winner), num_req);
  assign winner       = w_pick[id_width-1:0];
  assign any_eligible = w_pick[4];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the write port of an async FIFO; beats go straight to the FIFO.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int num_req    = NUM_REQ_DEF,
  parameter int data_width = 8,
  parameter int burst_max  = BURST_MAX_DEF,
  parameter int id_width   = $clog2(num_req)
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req*data_width-1:0] req_data,
  input  logic [num_req-1:0]            req_mask,
  output logic [num_req-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          wr_en,
  output logic [data_width-1:0]         data_in,
  output logic                          busy,
  output logic [id_width-1:0]           grant_id
);

  localparam int                CNT_W    = $clog2(burst_max + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(burst_max - 1);

  arb_state_t          r_state;
  logic [id_width-1:0] r_owner;
  logic [id_width-1:0] r_last;
  logic [CNT_W-1:0]    r_cnt;

  logic [num_req-1:0]    w_elig;
  logic [id_width-1:0]   w_winner;
  logic                  w_any;
  logic                  w_own_valid;
  logic                  w_own_mask;
  logic                  w_accept;
  logic                  w_end;
  logic [data_width-1:0] w_sel;

  assign w_elig = req_valid & req_mask;

  rr_pick #(
    .num_req  (num_req),
    .id_width (id_width)
  ) u_rr_pick (
    .eligible     (w_elig),
    .last_winner  (r_last),
    .winner       (w_winner),
    .any_eligible (w_any)
  );

  assign w_own_valid = req_valid[r_owner];
  assign w_own_mask  = req_mask[r_owner];
  // A masked owner transfers nothing in the cycle its mask drops.
  assign w_accept    = (r_state == BURST) & w_own_valid & w_own_mask & ~fifo_full;
  assign w_end       = (r_state == BURST) &
                       ((w_accept & (r_cnt == LAST_CNT)) | ~w_own_valid | ~w_own_mask);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < num_req; i++) begin
      if (r_owner == id_width'(i)) w_sel = req_data[i*data_width +: data_width];
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[r_owner] = 1'b1;
  end

  assign wr_en    = w_accept;
  assign data_in  = w_accept ? w_sel : '0;
  assign busy     = (r_state == BURST);
  assign grant_id = r_owner;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= id_width'(num_req - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_cnt   <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
          if (w_end) begin
            r_state <= IDLE;
            r_last  <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
